// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM states, oversampling
// constants and the baud divider calculation.
package uart_pkg;

  localparam int OVS       = 16;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO, depth 2**AW, combinational head output.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = count_q[AW];
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x oversampled 8N1 UART receiver with receive buffer and sticky error flags.
// Define UART_RX_FIFO_EN for a 2**FIFO_AW deep FIFO; otherwise one holding register.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 24000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       pop,
  input  logic       clr_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]    MID_SAMP  = 4'(OVS / 2 - 1);
  localparam logic [3:0]    LAST_SAMP = 4'(OVS - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     state_q;
  logic [3:0]    samp_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          push;
  logic          fe_set;
  logic          ov_set;
  logic          frame_err_q;
  logic          overrun_q;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Synchroniser resets to the idle line level so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          samp_q  <= '0;
        end
        START: begin
          if (samp_q == MID_SAMP) begin
            samp_q <= '0;
            bit_q  <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            samp_q <= samp_q + 4'd1;
          end
        end
        DATA: begin
          samp_q <= samp_q + 4'd1;
          if (samp_q == LAST_SAMP) begin
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == LAST_BIT) state_q <= STOP;
            else                   bit_q   <= bit_q + 3'd1;
          end
        end
        STOP: begin
          samp_q <= samp_q + 4'd1;
          if (samp_q == LAST_SAMP) state_q <= rx_s ? IDLE : BRK;
        end
        BRK: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stop-bit sample decides between delivering the byte and flagging a frame error.
  assign push   = tick && (state_q == STOP) && (samp_q == LAST_SAMP) && rx_s;
  assign fe_set = tick && (state_q == STOP) && (samp_q == LAST_SAMP) && !rx_s;

`ifdef UART_RX_FIFO_EN
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  uart_rx_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rx_valid = ~fifo_empty;
  assign ov_set   = push && fifo_full && !pop;

  always_comb assert (fifo_empty == (fifo_count == '0));
`else
  logic [7:0] hold_q;
  logic       valid_q;

  // A new byte always replaces the held one; losing an unread byte is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = hold_q;
  assign ov_set   = push && valid_q && !pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= fe_set | (frame_err_q & ~clr_err);
      overrun_q   <= ov_set | (overrun_q & ~clr_err);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: serial frames driven bit by bit, a queue model of
// the receive buffer, and a monitor that checks every byte the bench pops.
module tb_uart_rx_buffered;

  localparam int CLK_HZ = 24000000;
  localparam int BAUD   = 115200;
  localparam int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_FIFO_EN
  localparam int  DEPTH     = 16;
  localparam bit  FIFO_MODE = 1'b1;
`else
  localparam int  DEPTH     = 1;
  localparam bit  FIFO_MODE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       pop;
  logic       clr_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;

  uart_rx_buffered dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .pop       (pop),
    .clr_err   (clr_err),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pop && rx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_data unexpected: got 0x%0h expected no byte", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic model_push(input logic [7:0] d);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
    end else begin
      exp_ov = 1'b1;
      if (!FIFO_MODE) exp_q[exp_q.size() - 1] = d;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT);
    end
    rx = stop;
    idle(BIT);
    rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    send_byte(d, stop);
    if (stop) model_push(d);
    else      exp_fe = 1'b1;
  endtask

  // Good frame with the push cycle predicted from the start edge: the start bit is
  // seen 3 clk after driving, on the next tick (every DIV clk), mid-bit 8 ticks later,
  // then 9 bit periods to the stop sample.
  task automatic timed_frame(input logic [7:0] d, input bit pop_at_push);
    int n0;
    int t0;
    int push_cyc;
    n0 = cyc;
    t0 = ((n0 + 3 + DIV - 1) / DIV) * DIV;
    push_cyc = t0 + DIV * (8 + 16 * 9);
    fork
      send_byte(d, 1'b1);
      begin
        wait_cyc(push_cyc - 1);
        if (pop_at_push) pop = 1'b1;
        else check("rx_valid before stop sample", rx_valid, 0);
        wait_cyc(push_cyc);
        pop = 1'b0;
        check("rx_valid after stop sample", rx_valid, 1);
      end
    join
    model_push(d);
  endtask

  task automatic drain(input string tag);
    int expect_n;
    int got;
    expect_n = exp_q.size();
    got = 0;
    for (int i = 0; i < DEPTH + 4 && rx_valid; i++) begin
      pop = 1'b1;
      idle(1);
      got++;
    end
    pop = 1'b0;
    check({tag, " pop count"}, got, expect_n);
    check({tag, " rx_valid after drain"}, rx_valid, 0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, " frame_err"}, frame_err, exp_fe);
    check({tag, " overrun"}, overrun, exp_ov);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    pop = 1'b0;
    clr_err = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);

    // single byte with push latency
    timed_frame(8'hA5, 1'b0);
    check_flags("a5");
    drain("a5");

    // short low pulse must be rejected as a glitch
    rx = 1'b0;
    idle(60);
    rx = 1'b1;
    idle(400);
    check("glitch rx_valid", rx_valid, 0);
    check_flags("glitch");

    // stop bit low
    frame(8'h3C, 1'b0);
    idle(40);
    check("frame err rx_valid", rx_valid, 0);
    check_flags("frame err");
    clear_errors();
    check_flags("after clr_err");

    // fill the buffer, then push with a same-cycle pop, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      frame(8'(i), 1'b1);
      idle(20);
    end
    check_flags("filled");
    timed_frame(8'h10, 1'b1);
    check_flags("push with pop while full");
    idle(20);
    frame(8'h11, 1'b1);
    idle(20);
    check_flags("overflow");
    drain("overflow");
    clear_errors();
    check_flags("overflow cleared");

    // random frames, random stop-bit errors, random draining
    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      logic stop;
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      frame(d, stop);
      idle($urandom_range(20, 60));
      if ($urandom_range(0, 1) == 1) drain("random mid");
    end
    check_flags("random");
    drain("random end");
    clear_errors();

    // reset in the middle of 0xF0 (during data bit 4), then a clean 0x81
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      idle(BIT);
    end
    rx = 1'b1;
    idle(100);
    rst_n = 1'b0;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(300);
    timed_frame(8'h81, 1'b0);
    check_flags("after mid-frame reset");
    drain("after mid-frame reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
